screen_filler: RTL and testbench
================================

SCREEN_FILLER -- requirements
Module: screen_filler

Interface
REQ-001 SHALL have parameter H_RES, default 640, screen width in pixels.
REQ-002 SHALL have parameter V_RES, default 480, screen height in pixels.
REQ-003 SHALL have parameter CW, default 8, colour width in bits; XW = $clog2(H_RES) and YW = $clog2(V_RES) are derived localparams.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request fill of the latched region; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate an ongoing fill.
REQ-008 SHALL have ports x0, x1  input  XW, and y0, y1  input  YW  inclusive region corners.
REQ-009 SHALL have port color  input  CW  fill colour.
REQ-010 SHALL have port ready  input  1  downstream accepts the current pixel.
REQ-011 SHALL have ports x  output  XW, and y  output  YW  current pixel coordinate.
REQ-012 SHALL have port pix  output  CW  current pixel colour.
REQ-013 SHALL have port valid  output  1  x/y/pix hold a pixel to write.
REQ-014 SHALL have port busy  output  1  fill in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port count  output  XW+YW  pixels accepted in the current or last fill.

Function
REQ-017 SHALL implement states IDLE, FILL, DONE; all outputs registered.
REQ-018 In IDLE with start=1, SHALL latch x0, x1, y0, y1 and color, clip x1 to H_RES-1 and y1 to V_RES-1, and clear count.
REQ-019 After latching in IDLE, SHALL move to DONE if x0>x1 or y0>y1 after clipping (empty region, no pixels); otherwise SHALL move to FILL with x=x0, y=y0, valid=1 and busy=1 on the next cycle.
REQ-020 Transfer SHALL occur on any cycle with valid&ready; x, y, pix SHALL hold stable while valid&~ready.
REQ-021 On each transfer, SHALL increment count and advance in raster order: x+1 if x<x1, else x=x0 and y+1.
REQ-022 On transfer of pixel (x1,y1), SHALL deassert valid and busy and enter DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 abort in FILL SHALL take priority over a simultaneous transfer: pixel not counted, valid/busy low next cycle, enter DONE.
REQ-025 start in FILL or DONE SHALL be ignored; start held high in IDLE after DONE SHALL begin a new fill.
REQ-026 Minimum fill latency SHALL be region_pixels + 2 cycles (start to done) with ready tied high.

Reset
REQ-027 reset_n low SHALL immediately force IDLE with x=0, y=0, pix=0, valid=0, busy=0, done=0, count=0.
REQ-028 Reset mid-fill SHALL discard the fill; no done pulse SHALL follow.

Configuration
REQ-029 When macro SCREEN_FILLER_PATTERN_EN is defined, SHALL add input pattern (1 bit), latched with the region; when latched pattern=1, pix SHALL be color if (x^y) bit 0 = 0, else ~color (checkerboard).
REQ-030 When SCREEN_FILLER_PATTERN_EN is undefined, port pattern SHALL not exist and pix SHALL always equal the latched color.

Verification
REQ-031 SHALL test full screen: x0=0, y0=0, x1=639, y1=479, color=8'hFF, ready=1 -> 307200 transfers in raster order, done pulse, count=307200.
REQ-032 SHALL test backpressure: region (10,5)-(12,6), ready toggling 1/0 -> 6 pixels, each held stable while ready=0, and (12,5) followed by (10,6).
REQ-033 SHALL test clipping: x1=700, y1=500 with x0=638, y0=478 -> 4 pixels (638..639, 478..479).
REQ-034 SHALL test empty region: x0=5, x1=4 -> valid never high, done two cycles after start, count=0.
REQ-035 SHALL test abort on third pixel of (0,0)-(9,0) with ready=1 -> count=2, done pulse, no further valid.
REQ-036 SHALL test reset_n low mid-fill -> outputs at reset values immediately, no done pulse; with SCREEN_FILLER_PATTERN_EN defined and pattern=1, pixel (1,0) carries ~color.

Source files
------------

// File: rtl/screen_filler.sv
// Raster rectangle filler: emits x/y/pix for every pixel of a clipped inclusive region, row by row.
// Latency: first pixel one cycle after start; start-to-done spans region_pixels+2 cycles with ready high.
// Backpressure: valid/ready; x, y, pix hold while ready is low; abort ends the fill immediately.
// Optional feature macro SCREEN_FILLER_PATTERN_EN adds a 'pattern' input for a checkerboard fill.
module screen_filler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CW    = 8,
    localparam int XW   = $clog2(H_RES),
    localparam int YW   = $clog2(V_RES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [XW-1:0]      x0,
    input  logic [XW-1:0]      x1,
    input  logic [YW-1:0]      y0,
    input  logic [YW-1:0]      y1,
    input  logic [CW-1:0]      color,
`ifdef SCREEN_FILLER_PATTERN_EN
    input  logic               pattern,
`endif
    input  logic               ready,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [CW-1:0]      pix,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [XW+YW-1:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    state_t            state, state_nxt;
    logic [XW-1:0]     x_nxt;
    logic [YW-1:0]     y_nxt;
    logic [CW-1:0]     pix_nxt;
    logic              valid_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [XW+YW-1:0]  count_nxt;

    // Region and colour captured at start; only x_lo is needed for row wrap,
    // y_lo is never revisited so it is not kept.
    logic [XW-1:0]     x_lo, x_lo_nxt;
    logic [XW-1:0]     x_hi, x_hi_nxt;
    logic [YW-1:0]     y_hi, y_hi_nxt;
    logic [CW-1:0]     col, col_nxt;
    logic              pat_in;
    logic              pat_q;
    logic              pat_nxt;

    // Clipped right/bottom edges of the requested region
    logic [XW-1:0]     x1_clip;
    logic [YW-1:0]     y1_clip;

    // Raster successor of the current pixel
    logic [XW-1:0]     adv_x;
    logic [YW-1:0]     adv_y;
    logic              last_pix;

`ifdef SCREEN_FILLER_PATTERN_EN
    assign pat_in = pattern;
`else
    assign pat_in = 1'b0;
`endif

    // Colour of a pixel: checkerboard inverts colour where x and y parities differ
    function automatic logic [CW-1:0] shade(
        input logic [CW-1:0] c,
        input logic          p,
        input logic [XW-1:0] px,
        input logic [YW-1:0] py
    );
        return (p && (px[0] ^ py[0])) ? ~c : c;
    endfunction

    // Clip requested corners to the screen and derive the next raster position
    always_comb begin
        x1_clip  = (x1 > X_MAX) ? X_MAX : x1;
        y1_clip  = (y1 > Y_MAX) ? Y_MAX : y1;
        last_pix = (x == x_hi) && (y == y_hi);
        if (x < x_hi) begin
            adv_x = x + 1'b1;
            adv_y = y;
        end else begin
            adv_x = x_lo;
            adv_y = y + 1'b1;
        end
    end

    // Next-state and next-output logic for the IDLE/FILL/DONE sequencer
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        pix_nxt   = pix;
        valid_nxt = valid;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        count_nxt = count;
        x_lo_nxt  = x_lo;
        x_hi_nxt  = x_hi;
        y_hi_nxt  = y_hi;
        col_nxt   = col;
        pat_nxt   = pat_q;

        case (state)
            IDLE: begin
                if (start) begin
                    x_lo_nxt  = x0;
                    x_hi_nxt  = x1_clip;
                    y_hi_nxt  = y1_clip;
                    col_nxt   = color;
                    pat_nxt   = pat_in;
                    count_nxt = '0;
                    if ((x0 > x1_clip) || (y0 > y1_clip)) begin
                        // Empty region: straight to the completion pulse
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = FILL;
                        x_nxt     = x0;
                        y_nxt     = y0;
                        pix_nxt   = shade(color, pat_in, x0, y0);
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end
                end
            end

            FILL: begin
                if (abort) begin
                    // Abort wins over a transfer in the same cycle: pixel not counted
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (valid && ready) begin
                    count_nxt = count + 1'b1;
                    if (last_pix) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                    end else begin
                        x_nxt   = adv_x;
                        y_nxt   = adv_y;
                        pix_nxt = shade(col, pat_q, adv_x, adv_y);
                    end
                end
            end

            DONE: begin
                // One-cycle completion; start is not looked at here
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any fill without a done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            pix   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            x_lo  <= '0;
            x_hi  <= '0;
            y_hi  <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            pix   <= pix_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            count <= count_nxt;
            x_lo  <= x_lo_nxt;
            x_hi  <= x_hi_nxt;
            y_hi  <= y_hi_nxt;
            col   <= col_nxt;
        end
    end

`ifdef SCREEN_FILLER_PATTERN_EN
    // Latched checkerboard enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= 1'b0;
        end else begin
            pat_q <= pat_nxt;
        end
    end
`else
    assign pat_q = 1'b0;
`endif

endmodule

// File: tb/tb_screen_filler.sv
// Bench for screen_filler on a reduced 40x30 screen so a whole-screen fill stays short;
// the reference model enumerates each region with nested loops and compares in order.
// Covers full screen, backpressure, clipping, empty region, abort, start held high, reset.
module tb_screen_filler;

    localparam int H  = 40;
    localparam int V  = 30;
    localparam int CW = 8;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);
    localparam int CM = (1 << CW) - 1;

`ifdef SCREEN_FILLER_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
    logic pattern;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [XW-1:0]     x0, x1;
    logic [YW-1:0]     y0, y1;
    logic [CW-1:0]     color;
    logic              ready;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [CW-1:0]     pix;
    logic              valid;
    logic              busy;
    logic              done;
    logic [XW+YW-1:0]  count;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t expq[$];

    always #5 clk = ~clk;

    screen_filler #(.H_RES(H), .V_RES(V), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .x0      (x0),
        .x1      (x1),
        .y0      (y0),
        .y1      (y1),
        .color   (color),
`ifdef SCREEN_FILLER_PATTERN_EN
        .pattern (pattern),
`endif
        .ready   (ready),
        .x       (x),
        .y       (y),
        .pix     (pix),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected pixel sequence: clip, then rows top to bottom, columns left to right
    task automatic build(input int ax0, input int ax1, input int ay0, input int ay1,
                         input int col, input bit pat);
        int cx1, cy1;
        pix_t p;
        expq.delete();
        cx1 = (ax1 > H - 1) ? H - 1 : ax1;
        cy1 = (ay1 > V - 1) ? V - 1 : ay1;
        for (int yy = ay0; yy <= cy1; yy++) begin
            for (int xx = ax0; xx <= cx1; xx++) begin
                p.px = xx;
                p.py = yy;
                p.pc = (pat && PAT_ON && (((xx + yy) % 2) == 1)) ? (~col & CM) : col;
                expq.push_back(p);
            end
        end
    endtask

    // rmode: 0 ready high, 1 ready toggles 1/0, 2 random ready; abort_at<0 means no abort
    task automatic run_fill(input string tag, input int ax0, input int ax1, input int ay0,
                            input int ay1, input int col, input bit pat, input int rmode,
                            input int abort_at);
        int n, sent, exp_cnt, budget;
        bit got_done, tog;
        build(ax0, ax1, ay0, ay1, col, pat);
        n       = expq.size();
        exp_cnt = (abort_at >= 0 && abort_at < n) ? abort_at : n;
        budget  = 4 * n + 20;
        x0      = XW'(ax0);
        x1      = XW'(ax1);
        y0      = YW'(ay0);
        y1      = YW'(ay1);
        color   = CW'(col);
`ifdef SCREEN_FILLER_PATTERN_EN
        pattern = pat;
`endif
        start    = 1'b1;
        abort    = 1'b0;
        ready    = 1'b1;
        tog      = 1'b0;
        sent     = 0;
        got_done = 1'b0;
        for (int cyc = 1; cyc <= budget && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                got_done = 1'b1;
                chk({tag, ":done_valid"}, valid, 0);
                chk({tag, ":done_busy"}, busy, 0);
                chk({tag, ":count"}, count, exp_cnt);
                chk({tag, ":sent"}, sent, exp_cnt);
                if (rmode == 0 && abort_at < 0)
                    chk({tag, ":latency"}, cyc, n + 1);
            end else begin
                chk({tag, ":valid"}, valid, 1);
                chk({tag, ":busy"}, busy, 1);
                chk({tag, ":queue"}, expq.size() > 0, 1);
                if (valid && expq.size() > 0) begin
                    chk({tag, ":x"}, x, expq[0].px);
                    chk({tag, ":y"}, y, expq[0].py);
                    chk({tag, ":pix"}, pix, expq[0].pc);
                end
                case (rmode)
                    0:       ready = 1'b1;
                    1:       begin ready = tog ? 1'b0 : 1'b1; tog = ~tog; end
                    default: ready = ($urandom_range(0, 2) != 0);
                endcase
                if (abort_at >= 0 && sent == abort_at) begin
                    abort = 1'b1;
                    ready = 1'b1;
                end else if (valid && ready && expq.size() > 0) begin
                    void'(expq.pop_front());
                    sent++;
                end
            end
        end
        if (!got_done) begin
            chk({tag, ":timeout"}, 0, 1);
            reset_n = 1'b0;
            #2;
            reset_n = 1'b1;
        end
        @(negedge clk);
        chk({tag, ":after_done"}, done, 0);
        chk({tag, ":after_valid"}, valid, 0);
        ready = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=0 exp=1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx0, rx1, ry0, ry1, rab;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        ready   = 1'b1;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        color = '0;
`ifdef SCREEN_FILLER_PATTERN_EN
        pattern = 1'b0;
`endif
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_x", x, 0);
        chk("rst_pix", pix, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_fill("full", 0, H - 1, 0, V - 1, 8'hFF, 1'b0, 0, -1);
        run_fill("bp", 10, 12, 5, 6, 8'h5A, 1'b0, 1, -1);
        run_fill("clip", 38, 50, 28, 31, 8'h81, 1'b0, 0, -1);
        run_fill("empty", 5, 4, 0, 0, 8'h11, 1'b0, 0, -1);
        run_fill("abort", 0, 9, 0, 0, 8'h22, 1'b0, 0, 2);
        run_fill("pat", 0, 7, 0, 3, 8'h3C, 1'b1, 2, -1);

        // start held high: fill, done, idle, then a new fill, period three cycles
        x0 = 3; x1 = 3; y0 = 3; y1 = 3;
        color = 8'h77;
        ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("hold_valid", valid, (c % 3) == 1);
            chk("hold_done", done, (c % 3) == 2);
            if (c == 6) start = 1'b0;
        end
        @(negedge clk);
        chk("hold_idle", valid, 0);

        for (int i = 0; i < 6; i++) begin
            rx0 = $urandom_range(0, H - 1);
            rx1 = $urandom_range(0, (1 << XW) - 1);
            ry0 = $urandom_range(0, V - 1);
            ry1 = $urandom_range(0, (1 << YW) - 1);
            rab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_fill("rand", rx0, rx1, ry0, ry1, $urandom_range(0, CM),
                     1'(($urandom_range(0, 1))), 2, rab);
        end

        // reset mid-fill
        x0 = 0; x1 = 9; y0 = 0; y1 = 2;
        color = 8'hA5;
`ifdef SCREEN_FILLER_PATTERN_EN
        pattern = 1'b1;
`endif
        ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_x0", x, 0);
        @(negedge clk);
        chk("mid_x1", x, 1);
`ifdef SCREEN_FILLER_PATTERN_EN
        chk("mid_checker", pix, ~8'hA5 & CM);
`else
        chk("mid_pix", pix, 8'hA5);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_count", count, 0);
        chk("mrst_x", x, 0);
        chk("mrst_y", y, 0);
        chk("mrst_pix", pix, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("mrst_nodone", done, 0);
            chk("mrst_novalid", valid, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
